// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the pipeline and the HI/LO multiply-divide unit.
// The master launches operations and MTHI/MTLO writes; the slave owns HI/LO.
interface mult_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, src_a, src_b, wr_hi, wr_lo, wdata,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, wr_hi, wr_lo, wdata,
        output busy, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// MIPS-style HI/LO multiply/divide unit: the result is computed at launch and held
// pending for a fixed latency, then committed to HI/LO in one step.
module mult_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave md
);
    localparam logic [5:0] MUL_N = 6'(MUL_CYCLES);
    localparam logic [5:0] DIV_N = 6'(DIV_CYCLES);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;
    logic [31:0] dsr_s, dsr_u;
    logic        div_zero, div_ovf;

    always_comb begin
        div_zero = (md.src_b == 32'd0);
        div_ovf  = (md.src_a == 32'h8000_0000) && (md.src_b == 32'hFFFF_FFFF);
        // -2^31 / -1 wraps to -2^31 rem 0, which is exactly what dividing by +1 yields
        dsr_s    = (div_zero || div_ovf) ? 32'd1 : md.src_b;
        dsr_u    = div_zero ? 32'd1 : md.src_b;
        prod_s   = $signed({{32{md.src_a[31]}}, md.src_a}) * $signed({{32{md.src_b[31]}}, md.src_b});
        prod_u   = {32'd0, md.src_a} * {32'd0, md.src_b};
        quo_s    = $signed(md.src_a) / $signed(dsr_s);
        rem_s    = $signed(md.src_a) % $signed(dsr_s);
        quo_u    = md.src_a / dsr_u;
        rem_u    = md.src_a % dsr_u;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (md.start) begin
                    state_d = BUSY;
                    cnt_d   = md.op[1] ? DIV_N : MUL_N;
                    // A zero divisor re-commits the current HI/LO so the commit is a no-op
                    case (md.op)
                        2'd0:    {res_hi_d, res_lo_d} = prod_s;
                        2'd1:    {res_hi_d, res_lo_d} = prod_u;
                        2'd2:    {res_hi_d, res_lo_d} = div_zero ? {hi_q, lo_q} : {rem_s, quo_s};
                        default: {res_hi_d, res_lo_d} = div_zero ? {hi_q, lo_q} : {rem_u, quo_u};
                    endcase
                end else begin
                    if (md.wr_hi) hi_d = md.wdata;
                    if (md.wr_lo) lo_d = md.wdata;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    hi_d    = res_hi_q;
                    lo_d    = res_lo_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign md.busy = (state_q == BUSY);
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
endmodule
